// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial adder sequencer: state encoding and
// the bit-counter width helper.
package serial_adder_ctrl_pkg;

    // Controller states. The fourth encoding (2'd3) is unused and the FSM
    // returns to IDLE if it ever lands there.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit counter width. It must hold the value WIDTH so that it never wraps,
    // even though the largest value actually compared against is WIDTH-1.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell: the only arithmetic in the serial adder.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic in_carry,
    output logic sum,
    output logic out_carry
);

    logic half_sum;

    // Pure combinational sum and carry.
    always_comb begin
        half_sum  = a ^ b;
        sum       = half_sum ^ in_carry;
        out_carry = (a & b) | (in_carry & half_sum);
    end

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder sequencer. One full_adder cell is reused for WIDTH cycles,
// LSB first, with the carry held in a register between bits. Operands arrive
// on a valid/ready handshake and the result leaves on another one.
module serial_adder_ctrl
    import serial_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = cnt_width(WIDTH);
    // Count value seen on the edge that produces the MSB.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           state_reg;
    logic [WIDTH-1:0] a_sh_reg;
    logic [WIDTH-1:0] b_sh_reg;
    logic             carry_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [WIDTH-1:0] sum_reg;
    logic [WIDTH-1:0] sum_next;
    logic             cout_reg;
    logic             in_ready_reg;
    logic             out_valid_reg;

    logic             fa_sum;
    logic             fa_cout;

    // The single bit-slice datapath: current LSBs plus the running carry.
    full_adder u_full_adder (
        .a         (a_sh_reg[0]),
        .b         (b_sh_reg[0]),
        .in_carry  (carry_reg),
        .sum       (fa_sum),
        .out_carry (fa_cout)
    );

    // Result register shifts right; the new bit enters at the MSB so that
    // after WIDTH steps bit 0 of the operands has reached bit 0 of sum.
    // Written per bit so the same code also covers WIDTH=1 (no shift slice).
    generate
        for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_sum_shift
            assign sum_next[gi] = sum_reg[gi + 1];
        end
    endgenerate
    assign sum_next[WIDTH-1] = fa_sum;

    // Controller FSM together with its datapath registers and registered
    // handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            a_sh_reg      <= '0;
            b_sh_reg      <= '0;
            carry_reg     <= 1'b0;
            cnt_reg       <= '0;
            sum_reg       <= '0;
            cout_reg      <= 1'b0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    // Operands are captured here and never looked at again,
                    // so later changes on a/b/cin cannot affect the result.
                    if (in_valid) begin
                        a_sh_reg     <= a;
                        b_sh_reg     <= b;
                        carry_reg    <= cin;
                        cnt_reg      <= '0;
                        state_reg    <= RUN;
                        in_ready_reg <= 1'b0;
                    end
                end
                RUN: begin
                    sum_reg   <= sum_next;
                    carry_reg <= fa_cout;
                    a_sh_reg  <= a_sh_reg >> 1;
                    b_sh_reg  <= b_sh_reg >> 1;
                    cnt_reg   <= cnt_reg + 1'b1;
                    if (cnt_reg == LAST_CNT) begin
                        cout_reg      <= fa_cout;
                        state_reg     <= DONE;
                        out_valid_reg <= 1'b1;
                    end
                end
                DONE: begin
                    // Result is held until the consumer takes it; in_valid
                    // is deliberately ignored so nothing is queued.
                    if (out_ready) begin
                        state_reg     <= IDLE;
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    in_ready_reg  <= 1'b1;
                    out_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign sum       = sum_reg;
    assign cout      = cout_reg;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl at WIDTH=8 and WIDTH=1.
module tb_serial_adder_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // WIDTH=8 instance signals
    logic       rst8;
    logic       in_valid8;
    logic       in_ready8;
    logic [7:0] a8;
    logic [7:0] b8;
    logic       cin8;
    logic       out_valid8;
    logic       out_ready8;
    logic [7:0] sum8;
    logic       cout8;

    // WIDTH=1 instance signals
    logic       rst1;
    logic       in_valid1;
    logic       in_ready1;
    logic [0:0] a1;
    logic [0:0] b1;
    logic       cin1;
    logic       out_valid1;
    logic       out_ready1;
    logic [0:0] sum1;
    logic       cout1;

    int total = 0;
    int bad   = 0;

    serial_adder_ctrl #(.WIDTH(8)) dut8 (
        .clk       (clk),
        .rst       (rst8),
        .in_valid  (in_valid8),
        .in_ready  (in_ready8),
        .a         (a8),
        .b         (b8),
        .cin       (cin8),
        .out_valid (out_valid8),
        .out_ready (out_ready8),
        .sum       (sum8),
        .cout      (cout8)
    );

    serial_adder_ctrl #(.WIDTH(1)) dut1 (
        .clk       (clk),
        .rst       (rst1),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .a         (a1),
        .b         (b1),
        .cin       (cin1),
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .sum       (sum1),
        .cout      (cout1)
    );

    // Advance one rising edge and settle 1 ns past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst8 = 1'b1; rst1 = 1'b1;
        in_valid8 = 1'b0; a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0; out_ready8 = 1'b0;
        in_valid1 = 1'b0; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0; out_ready1 = 1'b0;
        step();
        step();
        rst8 = 1'b0; rst1 = 1'b0;
        total++;
        if ({in_ready8, out_valid8, sum8, cout8} !== {1'b1, 1'b0, 8'h00, 1'b0}) begin
            bad++;
            $display("FAIL reset8: got rdy=%b vld=%b sum=%h cout=%b want rdy=1 vld=0 sum=00 cout=0",
                     in_ready8, out_valid8, sum8, cout8);
        end
        total++;
        if ({in_ready1, out_valid1, sum1, cout1} !== {1'b1, 1'b0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset1: got rdy=%b vld=%b sum=%b cout=%b want rdy=1 vld=0 sum=0 cout=0",
                     in_ready1, out_valid1, sum1, cout1);
        end
        $display("reset applied");
    endtask

    // One full WIDTH=8 transaction. When scramble is set, operands are
    // overwritten right after the accepting edge.
    task automatic run_op8(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                           input logic [7:0] exp_sum, input logic exp_cout,
                           input bit scramble, input string name);
        int k;
        bit seen;
        total++;
        if (in_ready8 !== 1'b1) begin
            bad++;
            $display("FAIL %s_ready_before: got %b want 1", name, in_ready8);
        end
        in_valid8 = 1'b1; a8 = ta; b8 = tb; cin8 = tc;
        step();
        in_valid8 = 1'b0;
        if (scramble) begin
            a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
        end
        seen = 1'b0;
        k = 0;
        for (int i = 1; i <= 20; i++) begin
            total++;
            if (in_ready8 !== 1'b0) begin
                bad++;
                $display("FAIL %s_ready_busy: cycle %0d got %b want 0", name, i - 1, in_ready8);
            end
            step();
            if (out_valid8 === 1'b1) begin
                k = i;
                seen = 1'b1;
                break;
            end
        end
        total++;
        if (!seen || k != 8) begin
            bad++;
            $display("FAIL %s_latency: got %0d edges (seen=%0b) want 8", name, k, seen);
        end
        total++;
        if (sum8 !== exp_sum || cout8 !== exp_cout || in_ready8 !== 1'b0) begin
            bad++;
            $display("FAIL %s_result: got sum=%h cout=%b rdy=%b want sum=%h cout=%b rdy=0",
                     name, sum8, cout8, in_ready8, exp_sum, exp_cout);
        end
        out_ready8 = 1'b1;
        step();
        out_ready8 = 1'b0;
        total++;
        if (in_ready8 !== 1'b1 || out_valid8 !== 1'b0 || sum8 !== exp_sum || cout8 !== exp_cout) begin
            bad++;
            $display("FAIL %s_after_handshake: got rdy=%b vld=%b sum=%h cout=%b want rdy=1 vld=0 sum=%h cout=%b",
                     name, in_ready8, out_valid8, sum8, cout8, exp_sum, exp_cout);
        end
        a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0;
        $display("op %s: a=%h b=%h cin=%b -> sum=%h cout=%b latency=%0d", name, ta, tb, tc, sum8, cout8, k);
    endtask

    task automatic test_basic();
        run_op8(8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0, 1'b0, "basic_5a_33");
    endtask

    task automatic test_carry_edges();
        run_op8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, "ff_plus_01");
        run_op8(8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, "ff_plus_cin");
        run_op8(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, "zero");
    endtask

    task automatic test_backpressure();
        int k;
        // 0x12 + 0x34 + 1 = 0x47
        in_valid8 = 1'b1; a8 = 8'h12; b8 = 8'h34; cin8 = 1'b1;
        step();
        in_valid8 = 1'b0;
        k = 0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid8 === 1'b1) break;
            step();
            k++;
        end
        total++;
        if (out_valid8 !== 1'b1) begin
            bad++;
            $display("FAIL bp_reach_done: out_valid=%b after %0d edges want 1", out_valid8, k);
        end
        for (int i = 0; i < 5; i++) begin
            in_valid8 = i[0] ? 1'b0 : 1'b1;
            a8 = 8'hC0 + 8'(i); b8 = 8'h0F; cin8 = 1'b1;
            step();
            total++;
            if (out_valid8 !== 1'b1 || in_ready8 !== 1'b0 || sum8 !== 8'h47 || cout8 !== 1'b0) begin
                bad++;
                $display("FAIL bp_hold_%0d: got vld=%b rdy=%b sum=%h cout=%b want vld=1 rdy=0 sum=47 cout=0",
                         i, out_valid8, in_ready8, sum8, cout8);
            end
        end
        in_valid8 = 1'b0;
        out_ready8 = 1'b1;
        step();
        out_ready8 = 1'b0;
        total++;
        if (in_ready8 !== 1'b1 || out_valid8 !== 1'b0 || sum8 !== 8'h47) begin
            bad++;
            $display("FAIL bp_release: got rdy=%b vld=%b sum=%h want rdy=1 vld=0 sum=47",
                     in_ready8, out_valid8, sum8);
        end
        // One idle edge: nothing should have been queued from the pulses.
        step();
        total++;
        if (in_ready8 !== 1'b1 || out_valid8 !== 1'b0) begin
            bad++;
            $display("FAIL bp_no_queue: got rdy=%b vld=%b want rdy=1 vld=0", in_ready8, out_valid8);
        end
        a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0;
        $display("op backpressure: held 5 cycles, sum=%h cout=%b", sum8, cout8);
    endtask

    task automatic test_operand_change();
        run_op8(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b1, "operand_change");
    endtask

    task automatic test_reset_mid_run();
        in_valid8 = 1'b1; a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b0;
        step();
        in_valid8 = 1'b0;
        step();
        step();
        // rst on the third RUN edge, with a competing request present.
        rst8 = 1'b1; in_valid8 = 1'b1; a8 = 8'h77; b8 = 8'h77;
        step();
        rst8 = 1'b0; in_valid8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
        total++;
        if ({in_ready8, out_valid8, sum8, cout8} !== {1'b1, 1'b0, 8'h00, 1'b0}) begin
            bad++;
            $display("FAIL midrun_reset: got rdy=%b vld=%b sum=%h cout=%b want rdy=1 vld=0 sum=00 cout=0",
                     in_ready8, out_valid8, sum8, cout8);
        end
        step();
        total++;
        if (in_ready8 !== 1'b1 || out_valid8 !== 1'b0) begin
            bad++;
            $display("FAIL midrun_rst_dominates: got rdy=%b vld=%b want rdy=1 vld=0", in_ready8, out_valid8);
        end
        $display("op reset_mid_run: state cleared");
        run_op8(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, "after_reset");
    endtask

    task automatic test_width1();
        logic [7:0] sum_tab;
        logic [7:0] cout_tab;
        logic [2:0] v;
        int k;
        sum_tab  = 8'h96;  // parity of (a,b,cin) for index {a,b,cin}
        cout_tab = 8'hE8;  // majority of (a,b,cin)
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            total++;
            if (in_ready1 !== 1'b1) begin
                bad++;
                $display("FAIL w1_ready_%0d: got %b want 1", i, in_ready1);
            end
            in_valid1 = 1'b1; a1 = v[2]; b1 = v[1]; cin1 = v[0];
            step();
            in_valid1 = 1'b0;
            k = 0;
            for (int j = 1; j <= 5; j++) begin
                step();
                if (out_valid1 === 1'b1) begin
                    k = j;
                    break;
                end
            end
            total++;
            if (k != 1) begin
                bad++;
                $display("FAIL w1_latency_%0d: got %0d edges want 1", i, k);
            end
            total++;
            if (sum1 !== sum_tab[i] || cout1 !== cout_tab[i]) begin
                bad++;
                $display("FAIL w1_result_%0d: got sum=%b cout=%b want sum=%b cout=%b",
                         i, sum1, cout1, sum_tab[i], cout_tab[i]);
            end
            $display("op w1: a=%b b=%b cin=%b -> sum=%b cout=%b", v[2], v[1], v[0], sum1, cout1);
            out_ready1 = 1'b1;
            step();
            out_ready1 = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry_edges();
        test_backpressure();
        test_operand_change();
        test_reset_mid_run();
        test_width1();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
